// File: rtl/traffic_pkg.sv
// Shared state encodings, lamp codes and default timing for the traffic phase scheduler.
package traffic_pkg;

    typedef enum logic [2:0] {
        NSG   = 3'd0,
        NSY   = 3'd1,
        AR1   = 3'd2,
        EWG   = 3'd3,
        EWY   = 3'd4,
        AR2   = 3'd5,
        FLASH = 3'd6
    } state_e;

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;

    localparam int unsigned DEF_MIN_GREEN = 4;
    localparam int unsigned DEF_MAX_GREEN = 10;
    localparam int unsigned DEF_YELLOW_T  = 2;
    localparam int unsigned DEF_ALLRED_T  = 1;
    localparam int unsigned DEF_WALK_T    = 6;
    localparam int unsigned DEF_CNT_W     = 4;

    // flash_ph selects which approach shows yellow while flashing
    function automatic logic [2:0] ns_light_of(input state_e st, input logic flash_ph);
        case (st)
            NSG:     ns_light_of = GREEN;
            NSY:     ns_light_of = YELLOW;
            FLASH:   ns_light_of = flash_ph ? RED : YELLOW;
            default: ns_light_of = RED;
        endcase
    endfunction

    function automatic logic [2:0] ew_light_of(input state_e st, input logic flash_ph);
        case (st)
            EWG:     ew_light_of = GREEN;
            EWY:     ew_light_of = YELLOW;
            FLASH:   ew_light_of = flash_ph ? YELLOW : RED;
            default: ew_light_of = RED;
        endcase
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating up-counter cleared on the cycle a new state is entered.
module phase_timer #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    output logic [CNT_W-1:0] cnt,
    output logic [CNT_W-1:0] cnt_next
);

    always_comb begin
        if (clear) begin
            cnt_next = '0;
        end else if (&cnt) begin
            cnt_next = cnt;
        end else begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/traffic_phase_sched.sv
// Demand-actuated two-road signal scheduler with latched pedestrian walk.
// Optional flashing mode is built when FLASH_MODE_EN is defined.
module traffic_phase_sched
    import traffic_pkg::*;
#(
    parameter int unsigned MIN_GREEN = DEF_MIN_GREEN,
    parameter int unsigned MAX_GREEN = DEF_MAX_GREEN,
    parameter int unsigned YELLOW_T  = DEF_YELLOW_T,
    parameter int unsigned ALLRED_T  = DEF_ALLRED_T,
    parameter int unsigned WALK_T    = DEF_WALK_T,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ns_car,
    input  logic             ew_car,
    input  logic             ped_req,
`ifdef FLASH_MODE_EN
    input  logic             flash_req,
`endif
    output logic [2:0]       NS_light,
    output logic [2:0]       EW_light,
    output logic             walk,
    output logic             ped_ack,
    output logic             ped_pending,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] phase_cnt
);

    localparam logic [CNT_W-1:0] MIN_LAST  = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(WALK_T - 1);
    localparam logic [CNT_W-1:0] WALK_LIM  = CNT_W'(WALK_T);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_next;
    logic             grant_q, grant_d;
    logic             enter_ewg;
    logic             walk_done;
    logic             flash_go;
    logic             flash_ph_d;

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk      (clk),
        .rst      (rst),
        .clear    (state_d != state_q),
        .cnt      (phase_cnt),
        .cnt_next (cnt_next)
    );

`ifdef FLASH_MODE_EN
    logic [CNT_W-1:0] flash_cnt_q, flash_cnt_d;
    logic             flash_ph_q;

    assign flash_go = flash_req;

    // Lamp phase restarts on entry and toggles every YELLOW_T cycles while flashing
    always_comb begin
        flash_ph_d  = 1'b0;
        flash_cnt_d = '0;
        if (state_d == FLASH && state_q == FLASH) begin
            if (flash_cnt_q == YEL_LAST) begin
                flash_ph_d = ~flash_ph_q;
            end else begin
                flash_ph_d  = flash_ph_q;
                flash_cnt_d = flash_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flash_cnt_q <= '0;
            flash_ph_q  <= 1'b0;
        end else begin
            flash_cnt_q <= flash_cnt_d;
            flash_ph_q  <= flash_ph_d;
        end
    end
`else
    assign flash_go   = 1'b0;
    assign flash_ph_d = 1'b0;
`endif

    // A granted walk holds EWG until it has run its full length, even past max green
    assign walk_done = !grant_q || (phase_cnt >= WALK_LAST);
    assign enter_ewg = (state_d == EWG) && (state_q != EWG);

    always_comb begin
        state_d = state_q;
        case (state_q)
            NSG: begin
                if (phase_cnt >= MIN_LAST && (ew_car || ped_pending) &&
                    (!ns_car || phase_cnt >= MAX_LAST)) begin
                    state_d = NSY;
                end
            end
            NSY: if (phase_cnt == YEL_LAST) state_d = AR1;
            AR1: if (phase_cnt == AR_LAST) state_d = flash_go ? FLASH : EWG;
            EWG: begin
                if (phase_cnt >= MIN_LAST && walk_done && ns_car &&
                    (!ew_car || phase_cnt >= MAX_LAST)) begin
                    state_d = EWY;
                end
            end
            EWY: if (phase_cnt == YEL_LAST) state_d = AR2;
            AR2: if (phase_cnt == AR_LAST) state_d = flash_go ? FLASH : NSG;
            FLASH: if (!flash_go) state_d = AR2;
            default: state_d = NSG;
        endcase
    end

    always_comb begin
        grant_d = 1'b0;
        if (enter_ewg) begin
            grant_d = ped_pending;
        end else if (state_d == EWG) begin
            grant_d = grant_q;
        end
    end

    // Outputs are decoded from the next state so lamps switch with the state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= NSG;
            grant_q     <= 1'b0;
            NS_light    <= GREEN;
            EW_light    <= RED;
            walk        <= 1'b0;
            ped_ack     <= 1'b0;
            ped_pending <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            NS_light    <= ns_light_of(state_d, flash_ph_d);
            EW_light    <= ew_light_of(state_d, flash_ph_d);
            walk        <= (state_d == EWG) && grant_d && (cnt_next < WALK_LIM);
            ped_ack     <= enter_ewg && ped_pending;
            // Pending clears after the ack cycle; a new press in that cycle keeps it set
            ped_pending <= ped_req || (ped_pending && !ped_ack);
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_traffic_phase_sched.sv
// Directed bench for traffic_phase_sched: timing sequences, walk grant and async reset.
module tb_traffic_phase_sched;

    localparam int NSG = 0, NSY = 1, AR1 = 2, EWG = 3, EWY = 4, AR2 = 5;
    localparam logic [2:0] RED = 3'b100, YEL = 3'b010, GRN = 3'b001;

    logic       clk, rst, ns_car, ew_car, ped_req;
    logic [2:0] NS_light, EW_light, state;
    logic       walk, ped_ack, ped_pending;
    logic [3:0] phase_cnt;
`ifdef FLASH_MODE_EN
    logic       flash_req = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    traffic_phase_sched dut (
        .clk         (clk),
        .rst         (rst),
        .ns_car      (ns_car),
        .ew_car      (ew_car),
        .ped_req     (ped_req),
`ifdef FLASH_MODE_EN
        .flash_req   (flash_req),
`endif
        .NS_light    (NS_light),
        .EW_light    (EW_light),
        .walk        (walk),
        .ped_ack     (ped_ack),
        .ped_pending (ped_pending),
        .state       (state),
        .phase_cnt   (phase_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] ns_exp(input int st);
        if (st == NSG) return GRN;
        if (st == NSY) return YEL;
        return RED;
    endfunction

    function automatic logic [2:0] ew_exp(input int st);
        if (st == EWG) return GRN;
        if (st == EWY) return YEL;
        return RED;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset(input string tag);
        check({tag, " state"}, 32'(state), 32'(NSG));
        check({tag, " cnt"}, 32'(phase_cnt), 32'd0);
        check({tag, " ns"}, 32'(NS_light), 32'(GRN));
        check({tag, " ew"}, 32'(EW_light), 32'(RED));
        check({tag, " walk"}, 32'(walk), 32'd0);
        check({tag, " ack"}, 32'(ped_ack), 32'd0);
        check({tag, " pend"}, 32'(ped_pending), 32'd0);
    endtask

    task automatic apply_reset(input string tag);
        rst = 1'b0;
        #1;
        check_reset(tag);
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    // Checks cycles first..last of a state, advancing one clock after each
    task automatic expect_phase(input string tag, input int st, input int first,
                                input int last, input int walk_n);
        for (int c = first; c <= last; c++) begin
            check({tag, " state"}, 32'(state), 32'(st));
            check({tag, " cnt"}, 32'(phase_cnt), 32'((c > 15) ? 15 : c));
            check({tag, " ns"}, 32'(NS_light), 32'(ns_exp(st)));
            check({tag, " ew"}, 32'(EW_light), 32'(ew_exp(st)));
            check({tag, " walk"}, 32'(walk), 32'(c < walk_n));
            tick();
        end
    endtask

    initial begin
        rst = 1'b1; ns_car = 1'b0; ew_car = 1'b0; ped_req = 1'b0;
        #2;

        // No demand: NSG rests, counter saturates
        apply_reset("rst0");
        expect_phase("idle", NSG, 0, 49, 0);

        // EW demand only: minimum NS green, then EWG rests
        ew_car = 1'b1;
        apply_reset("rst1");
        expect_phase("ew nsg", NSG, 0, 3, 0);
        expect_phase("ew nsy", NSY, 0, 1, 0);
        expect_phase("ew ar1", AR1, 0, 0, 0);
        expect_phase("ew ewg", EWG, 0, 19, 0);

        // Both demands: 26-cycle max-green rotation, twice
        ns_car = 1'b1;
        apply_reset("rst2");
        for (int p = 0; p < 2; p++) begin
            expect_phase("both nsg", NSG, 0, 9, 0);
            expect_phase("both nsy", NSY, 0, 1, 0);
            expect_phase("both ar1", AR1, 0, 0, 0);
            expect_phase("both ewg", EWG, 0, 9, 0);
            expect_phase("both ewy", EWY, 0, 1, 0);
            expect_phase("both ar2", AR2, 0, 0, 0);
        end

        // Pedestrian only on EW side
        ew_car = 1'b0;
        apply_reset("rst3");
        expect_phase("ped nsg", NSG, 0, 1, 0);
        ped_req = 1'b1;
        expect_phase("ped nsg", NSG, 2, 2, 0);
        ped_req = 1'b0;
        check("ped latched", 32'(ped_pending), 32'd1);
        expect_phase("ped nsg", NSG, 3, 9, 0);
        expect_phase("ped nsy", NSY, 0, 1, 0);
        expect_phase("ped ar1", AR1, 0, 0, 0);
        check("ped ack", 32'(ped_ack), 32'd1);
        expect_phase("ped ewg", EWG, 0, 0, 6);
        check("ped ack end", 32'(ped_ack), 32'd0);
        check("ped cleared", 32'(ped_pending), 32'd0);
        expect_phase("ped ewg", EWG, 1, 5, 6);
        expect_phase("ped ewy", EWY, 0, 1, 0);
        expect_phase("ped ar2", AR2, 0, 0, 0);
        expect_phase("ped rest", NSG, 0, 5, 0);

        // Request coinciding with the ack keeps pending for the next EWG
        ped_req = 1'b1;
        expect_phase("co nsg", NSG, 6, 6, 0);
        ped_req = 1'b0;
        expect_phase("co nsg", NSG, 7, 9, 0);
        expect_phase("co nsy", NSY, 0, 1, 0);
        expect_phase("co ar1", AR1, 0, 0, 0);
        check("co ack", 32'(ped_ack), 32'd1);
        ped_req = 1'b1;
        expect_phase("co ewg", EWG, 0, 0, 6);
        ped_req = 1'b0;
        check("co set wins", 32'(ped_pending), 32'd1);
        check("co ack end", 32'(ped_ack), 32'd0);
        expect_phase("co ewg", EWG, 1, 5, 6);
        expect_phase("co ewy", EWY, 0, 1, 0);
        expect_phase("co ar2", AR2, 0, 0, 0);
        expect_phase("co nsg2", NSG, 0, 9, 0);
        expect_phase("co nsy2", NSY, 0, 1, 0);
        expect_phase("co ar1b", AR1, 0, 0, 0);
        check("co ack2", 32'(ped_ack), 32'd1);
        expect_phase("co ewg2", EWG, 0, 1, 6);
        check("co cleared2", 32'(ped_pending), 32'd0);

        // Mid-EWG request waits; async reset in EWY drops it
        ped_req = 1'b1;
        expect_phase("mid ewg", EWG, 2, 2, 6);
        ped_req = 1'b0;
        check("mid pend", 32'(ped_pending), 32'd1);
        check("mid no ack", 32'(ped_ack), 32'd0);
        expect_phase("mid ewg", EWG, 3, 5, 6);
        expect_phase("mid ewy", EWY, 0, 0, 0);
        apply_reset("rst ewy");
        expect_phase("post rst", NSG, 0, 4, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
